// File: rtl/ebr_access_arbiter_pkg.sv
// Shared constants and swap-state type for the EBR double-buffer access arbiter.
package display_pkg;
    localparam int LINES        = 64;
    localparam int LINE_W       = 6;
    localparam int DATA_W       = 64;
    localparam int ADDR_W       = LINE_W + 1;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        SWAP_IDLE = 1'b0,
        SWAP_PEND = 1'b1
    } swap_state_t;

    // EBR address is the bank bit on top of the line index.
    function automatic logic [ADDR_W-1:0] ebr_addr(input logic bank, input logic [LINE_W-1:0] line);
        return {bank, line};
    endfunction
endpackage

// File: rtl/ebr_access_arbiter_if.sv
// Request, memory and buffer-status signals of the EBR access arbiter.
interface ebr_access_arbiter_if;
    import display_pkg::*;

    logic              wr_req;
    logic [LINE_W-1:0] wr_line;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [LINE_W-1:0] rd_line;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              frame_done;
    logic              vblank;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              front_sel;
    logic              swap_pulse;

    modport slave (
        input  wr_req, wr_line, wr_data, rd_req, rd_line, frame_done, vblank, mem_rdata,
        output wr_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, front_sel, swap_pulse
    );

    modport master (
        output wr_req, wr_line, wr_data, rd_req, rd_line, frame_done, vblank, mem_rdata,
        input  wr_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, front_sel, swap_pulse
    );
endinterface

// File: rtl/ebr_access_arbiter_swap.sv
// Front/back buffer swap FSM: a finished frame waits in PEND until the next vblank.
module buffer_swap_fsm
    import display_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic frame_done,
    input  logic vblank,
    output logic front_sel,
    output logic swap_pulse,
    output logic pend
);

    swap_state_t state_q, state_d;
    logic        front_q, front_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SWAP_IDLE;
            front_q <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
        end
    end

    // vblank is ignored in IDLE (even alongside frame_done) and frame_done in PEND.
    always_comb begin
        state_d    = state_q;
        front_d    = front_q;
        swap_pulse = 1'b0;
        case (state_q)
            SWAP_IDLE: begin
                if (frame_done) state_d = SWAP_PEND;
            end
            SWAP_PEND: begin
                if (vblank) begin
                    state_d    = SWAP_IDLE;
                    front_d    = ~front_q;
                    swap_pulse = 1'b1;
                end
            end
            default: state_d = SWAP_IDLE;
        endcase
        if (reset) swap_pulse = 1'b0;
    end

    assign front_sel = front_q;
    assign pend      = (state_q == SWAP_PEND);

endmodule

// File: rtl/ebr_access_arbiter.sv
// Single-port EBR arbiter: display reads from the front bank, SPI writes to the back bank.
// Optional write-starvation guard enabled by defining EBR_ARB_STARVE_GUARD_EN.
module ebr_access_arbiter
    import display_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    ebr_access_arbiter_if.slave bus
);

    logic pend;
    logic front_sel;
    logic swap_pulse;
    logic rd_grant;
    logic wr_grant;
    logic force_wr;
    logic rd_valid_q;

    buffer_swap_fsm u_swap (
        .clk        (clk),
        .reset      (reset),
        .frame_done (bus.frame_done),
        .vblank     (bus.vblank),
        .front_sel  (front_sel),
        .swap_pulse (swap_pulse),
        .pend       (pend)
    );

`ifdef EBR_ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_cnt;

    // Only denials caused by a competing read count; PEND stalls do not.
    always_ff @(posedge clk) begin
        if (reset || wr_grant) begin
            starve_cnt <= '0;
        end else if (bus.wr_req && rd_grant && !pend) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign force_wr = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && bus.wr_req && !pend;
`else
    assign force_wr = 1'b0;
`endif

    // One access per cycle: forced write, then read, then write unless a frame is pending.
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (!reset) begin
            if (force_wr) begin
                wr_grant = 1'b1;
            end else if (bus.rd_req) begin
                rd_grant = 1'b1;
            end else if (bus.wr_req && !pend) begin
                wr_grant = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_en    = rd_grant | wr_grant;
        bus.mem_we    = wr_grant;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rd_grant) begin
            bus.mem_addr = ebr_addr(front_sel, bus.rd_line);
        end else if (wr_grant) begin
            bus.mem_addr  = ebr_addr(~front_sel, bus.wr_line);
            bus.mem_wdata = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_grant;
        end
    end

    // The EBR output register holds the read data, so it is forwarded in the valid cycle.
    assign bus.rd_valid   = rd_valid_q & ~reset;
    assign bus.rd_data    = bus.rd_valid ? bus.mem_rdata : '0;
    assign bus.wr_ack     = wr_grant;
    assign bus.front_sel  = front_sel;
    assign bus.swap_pulse = swap_pulse;

endmodule

// File: tb/tb_ebr_access_arbiter.sv
// Directed bench for ebr_access_arbiter: vector table plus hand-written swap/starve/reset sequences.
module tb_ebr_access_arbiter;
    import display_pkg::*;

    typedef struct {
        logic              reset;
        logic              rd_req;
        logic [LINE_W-1:0] rd_line;
        logic              wr_req;
        logic [LINE_W-1:0] wr_line;
        logic [DATA_W-1:0] wr_data;
        logic              frame_done;
        logic              vblank;
        logic              exp_mem_en;
        logic              exp_mem_we;
        logic [ADDR_W-1:0] exp_mem_addr;
        logic [DATA_W-1:0] exp_mem_wdata;
        logic              exp_wr_ack;
        logic              exp_rd_valid;
        logic [DATA_W-1:0] exp_rd_data;
        logic              exp_front_sel;
        logic              exp_swap_pulse;
    } vec_t;

    localparam logic [63:0] FC = 64'hFCFC_FCFC_FCFC_FCFC;
    localparam logic [63:0] D1 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3 = 64'hAAAA_BBBB_CCCC_DDDD;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[9];

    bit [63:0] mem[128];
    bit        written[128];

    ebr_access_arbiter_if bus();

    ebr_access_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [6:0] a);
        return {32'hC0DE_5A5A, 25'h0, a};
    endfunction

    // EBR model: unwritten words read back a per-address pattern, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr] : pat(bus.mem_addr);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rq, input logic [5:0] rl, input logic wq,
                         input logic [5:0] wl, input logic [63:0] wd, input logic fd, input logic vb);
        @(posedge clk);
        #1;
        reset          = r;
        bus.rd_req     = rq;
        bus.rd_line    = rl;
        bus.wr_req     = wq;
        bus.wr_line    = wl;
        bus.wr_data    = wd;
        bus.frame_done = fd;
        bus.vblank     = vb;
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input vec_t v);
        drive(v.reset, v.rd_req, v.rd_line, v.wr_req, v.wr_line, v.wr_data, v.frame_done, v.vblank);
    endtask

    task automatic check_output(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, ".mem_en"},     64'(bus.mem_en),     64'(v.exp_mem_en));
        check({tag, ".mem_we"},     64'(bus.mem_we),     64'(v.exp_mem_we));
        check({tag, ".mem_addr"},   64'(bus.mem_addr),   64'(v.exp_mem_addr));
        check({tag, ".mem_wdata"},  bus.mem_wdata,       v.exp_mem_wdata);
        check({tag, ".wr_ack"},     64'(bus.wr_ack),     64'(v.exp_wr_ack));
        check({tag, ".rd_valid"},   64'(bus.rd_valid),   64'(v.exp_rd_valid));
        check({tag, ".rd_data"},    bus.rd_data,         v.exp_rd_data);
        check({tag, ".front_sel"},  64'(bus.front_sel),  64'(v.exp_front_sel));
        check({tag, ".swap_pulse"}, 64'(bus.swap_pulse), 64'(v.exp_swap_pulse));
    endtask

    initial begin
        reset          = 1'b1;
        bus.rd_req     = 1'b0;
        bus.rd_line    = '0;
        bus.wr_req     = 1'b0;
        bus.wr_line    = '0;
        bus.wr_data    = '0;
        bus.frame_done = 1'b0;
        bus.vblank     = 1'b0;

        // reset rd_rq rl wr_rq wl wd fd vb | en we addr wdata ack rv rdata front swap
        vecs[0] = '{1'b1, 1'b1, 6'd5,  1'b1, 6'd63, FC, 1'b0, 1'b1,
                    1'b0, 1'b0, 7'h00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 6'd5,  1'b0, 6'd0,  64'h0, 1'b0, 1'b0,
                    1'b1, 1'b0, 7'h05, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  64'h0, 1'b0, 1'b0,
                    1'b0, 1'b0, 7'h00, 64'h0, 1'b0, 1'b1, pat(7'h05), 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd63, FC, 1'b0, 1'b0,
                    1'b1, 1'b1, 7'h7F, FC, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 6'd10, 1'b1, 6'd3,  D1, 1'b0, 1'b0,
                    1'b1, 1'b0, 7'h0A, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd3,  D1, 1'b0, 1'b0,
                    1'b1, 1'b1, 7'h43, D1, 1'b1, 1'b1, pat(7'h0A), 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 6'd63, 1'b0, 6'd0,  64'h0, 1'b0, 1'b0,
                    1'b1, 1'b0, 7'h3F, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  64'h0, 1'b0, 1'b1,
                    1'b0, 1'b0, 7'h00, 64'h0, 1'b0, 1'b1, pat(7'h3F), 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  64'h0, 1'b0, 1'b0,
                    1'b0, 1'b0, 7'h00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        $display("[TB] read/write contention held for 6 cycles");
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b1, 6'd1, 1'b1, 6'd2, D1, 1'b0, 1'b0);
`ifdef EBR_ARB_STARVE_GUARD_EN
            check($sformatf("starve.c%0d.wr_ack", i), 64'(bus.wr_ack), 64'(i == 5));
            check($sformatf("starve.c%0d.mem_addr", i), 64'(bus.mem_addr), (i == 5) ? 64'h42 : 64'h01);
`else
            check($sformatf("starve.c%0d.wr_ack", i), 64'(bus.wr_ack), 64'h0);
            check($sformatf("starve.c%0d.mem_addr", i), 64'(bus.mem_addr), 64'h01);
`endif
        end
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);

        $display("[TB] frame_done, writes stalled, swap on vblank");
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0);
        check("swapB.fd.swap_pulse", 64'(bus.swap_pulse), 64'h0);
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd7, D2, 1'b0, 1'b0);
            check($sformatf("swapB.stall%0d.wr_ack", i), 64'(bus.wr_ack), 64'h0);
            check($sformatf("swapB.stall%0d.mem_en", i), 64'(bus.mem_en), 64'h0);
        end
        drive(1'b0, 1'b1, 6'd9, 1'b1, 6'd7, D2, 1'b0, 1'b1);
        check("swapB.vb.swap_pulse", 64'(bus.swap_pulse), 64'h1);
        check("swapB.vb.front_sel", 64'(bus.front_sel), 64'h0);
        check("swapB.vb.wr_ack", 64'(bus.wr_ack), 64'h0);
        check("swapB.vb.rd_addr", 64'(bus.mem_addr), 64'h09);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd7, D2, 1'b0, 1'b0);
        check("swapB.post.front_sel", 64'(bus.front_sel), 64'h1);
        check("swapB.post.swap_pulse", 64'(bus.swap_pulse), 64'h0);
        check("swapB.post.wr_ack", 64'(bus.wr_ack), 64'h1);
        check("swapB.post.mem_we", 64'(bus.mem_we), 64'h1);
        check("swapB.post.mem_addr", 64'(bus.mem_addr), 64'h07);
        check("swapB.post.rd_valid", 64'(bus.rd_valid), 64'h1);
        check("swapB.post.rd_data", bus.rd_data, pat(7'h09));
        drive(1'b0, 1'b1, 6'd9, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
        check("swapB.newbank.mem_addr", 64'(bus.mem_addr), 64'h49);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
        check("swapB.newbank.rd_data", bus.rd_data, pat(7'h49));

        $display("[TB] frame_done and vblank together");
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b1);
        check("swapC.both.swap_pulse", 64'(bus.swap_pulse), 64'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd12, D3, 1'b1, 1'b0);
        check("swapC.pend.front_sel", 64'(bus.front_sel), 64'h1);
        check("swapC.pend.wr_ack", 64'(bus.wr_ack), 64'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd12, D3, 1'b0, 1'b0);
        check("swapC.pend2.wr_ack", 64'(bus.wr_ack), 64'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd12, D3, 1'b0, 1'b1);
        check("swapC.vb.swap_pulse", 64'(bus.swap_pulse), 64'h1);
        check("swapC.vb.wr_ack", 64'(bus.wr_ack), 64'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd12, D3, 1'b0, 1'b0);
        check("swapC.post.front_sel", 64'(bus.front_sel), 64'h0);
        check("swapC.post.wr_ack", 64'(bus.wr_ack), 64'h1);
        check("swapC.post.mem_addr", 64'(bus.mem_addr), 64'h4C);
        check("swapC.post.mem_wdata", bus.mem_wdata, D3);

        $display("[TB] reset while a frame is pending");
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b0, 1'b1);
        check("rstD.swap.swap_pulse", 64'(bus.swap_pulse), 64'h1);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0);
        check("rstD.fs1.front_sel", 64'(bus.front_sel), 64'h1);
        drive(1'b0, 1'b1, 6'd20, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
        check("rstD.rd.mem_addr", 64'(bus.mem_addr), 64'h54);
        drive(1'b1, 1'b1, 6'd20, 1'b1, 6'd5, D1, 1'b0, 1'b1);
        check("rstD.in.mem_en", 64'(bus.mem_en), 64'h0);
        check("rstD.in.mem_we", 64'(bus.mem_we), 64'h0);
        check("rstD.in.mem_addr", 64'(bus.mem_addr), 64'h0);
        check("rstD.in.mem_wdata", bus.mem_wdata, 64'h0);
        check("rstD.in.wr_ack", 64'(bus.wr_ack), 64'h0);
        check("rstD.in.rd_valid", 64'(bus.rd_valid), 64'h0);
        check("rstD.in.rd_data", bus.rd_data, 64'h0);
        check("rstD.in.swap_pulse", 64'(bus.swap_pulse), 64'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
        check("rstD.out.front_sel", 64'(bus.front_sel), 64'h0);
        check("rstD.out.swap_pulse", 64'(bus.swap_pulse), 64'h0);
        check("rstD.out.rd_valid", 64'(bus.rd_valid), 64'h0);
        check("rstD.out.mem_en", 64'(bus.mem_en), 64'h0);
        check("rstD.out.wr_ack", 64'(bus.wr_ack), 64'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd33, D2, 1'b0, 1'b0);
        check("rstD.idle.wr_ack", 64'(bus.wr_ack), 64'h1);
        check("rstD.idle.mem_addr", 64'(bus.mem_addr), 64'h61);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b0, 1'b1);
        check("rstD.idle.vb.swap_pulse", 64'(bus.swap_pulse), 64'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
        check("rstD.idle.front_sel", 64'(bus.front_sel), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
